scie_arbiter: RTL and testbench
===============================

SCIE_ARBITER -- requirements
Module: scie_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: fixed clock cycles from an issue on scie_valid to a valid scie_rd; legal range 1..4.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; 0 sampled on a rising edge resets the block.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an instruction.
REQ-005 reqN_ready  output  1  requester N is granted this cycle; a transfer fires when reqN_valid and reqN_ready are both 1.
REQ-006 reqN_insn / reqN_rs1 / reqN_rs2  input  32 each  instruction word and operands of requester N.
REQ-007 reqN_lock  input  1  keep the grant on N after this transfer (multi-instruction sequence).
REQ-008 rspN_valid  output  1  one-cycle pulse: result for requester N is on rspN_rd.
REQ-009 rspN_rd  output  32  result for requester N.
REQ-010 scie_valid / scie_insn / scie_rs1 / scie_rs2  output  1/32/32/32  issue port to the shared SCIE pipelined unit.
REQ-011 scie_rd  input  32  SCIE result, valid LATENCY cycles after the matching issue.

Function
REQ-012 At most one transfer fires per cycle; reqN_ready depends combinationally on the reqN_valid inputs and on state only, never on insn or operands.
REQ-013 State machine: IDLE, LOCK0, LOCK1.
- IDLE: if only one requester is valid, it is granted.
- IDLE, both valid: the requester holding the 1-bit priority pointer is granted.
REQ-014 After every fired transfer from N, the priority pointer points to the other requester.
REQ-015 In LOCKn, only requester n may be granted; the other requester's ready is 0, even when reqn_valid is 0.
REQ-016 State transitions on a fired transfer from N:
- IDLE to LOCKN when reqN_lock=1.
- LOCKN to IDLE when reqN_lock=0.
- Otherwise the state is unchanged.
REQ-017 On a fired transfer, scie_valid=1 in the same cycle and scie_insn/rs1/rs2 equal the granted requester's fields; when nothing fires, scie_valid=0 and scie_insn/rs1/rs2 are 0.
REQ-018 A LATENCY-deep tag shift register of {valid, id} records each issue.
- When a tag exits, rspid_valid=1 and rspid_rd=scie_rd (combinational) in that cycle.
- Otherwise rspN_valid=0 and rspN_rd=0.
REQ-019 Responses are delivered in issue order and are never back-pressured; one issue per cycle is sustained with no bubbles.
REQ-020 Simultaneous events: a response exit and a new issue in the same cycle are both served.

Reset
REQ-021 On reset, the block SHALL:
- set state to IDLE and the priority pointer to 0;
- clear every tag valid bit;
- drive all outputs to 0.
REQ-022 Operations issued before reset SHALL never produce rspN_valid; a lock in force at reset is dropped.

Configuration
REQ-023 With SCIE_ARB_PERF_EN defined, the block SHALL add three 32-bit output counters, each cleared by reset and wrapping at 2^32:
- perf_issue0 and perf_issue1: fired transfers per requester;
- perf_conflict: cycles in which some reqN_valid=1 while reqN_ready=0.
REQ-024 Without SCIE_ARB_PERF_EN, these ports and counters SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-025 LATENCY=1, req0 only, insn=0x0B, rs1=6, rs2=0 -> ready0=1 and scie_valid=1 with the same fields in cycle 0; rsp0_valid=1 in cycle 1 with rsp0_rd=scie_rd; rsp1_valid stays 0.
REQ-026 Both requesters valid for 6 cycles after reset -> grants 0,1,0,1,0,1; responses alternate rsp0/rsp1, each one cycle after its issue.
REQ-027 Lock sequence; req1 valid throughout:
- req0 issues 0x2B with lock=1, idles 2 cycles, then issues 0x5B with lock=0;
- req1_ready stays 0 until the 0x5B transfer;
- req1 is granted in the following cycle.
REQ-028 Reset mid-operation: req1 fires, reset=0 in the next cycle -> no rsp1_valid ever; after release, state is IDLE and with both valid req0 is granted first.
REQ-029 LATENCY=3, back-to-back issues from 0,1,0 in cycles 0-2 -> rsp0, rsp1, rsp0 in cycles 3, 4, 5 carrying the scie_rd of those cycles.
REQ-030 SCIE_ARB_PERF_EN defined, both requesters valid for 10 cycles -> perf_issue0=5, perf_issue1=5, perf_conflict=10.

Source files
------------

// File: rtl/scie_arbiter_if.sv
// scie_arbiter_if: one requester channel of the SCIE arbiter
// master = requester side, slave = arbiter side
// valid/ready/lock : issue handshake; lock holds the grant after this transfer
// insn/rs1/rs2     : instruction word and operands
// rsp_valid/rsp_rd : one-cycle result pulse and result data
interface scie_arbiter_if;
   logic        valid, ready, lock, rsp_valid;
   logic [31:0] insn, rs1, rs2, rsp_rd;
   modport master(output valid, lock, insn, rs1, rs2, input ready, rsp_valid, rsp_rd);
   modport slave(input valid, lock, insn, rs1, rs2, output ready, rsp_valid, rsp_rd);
endinterface

// File: rtl/scie_arbiter.sv
// scie_arbiter: two-requester arbiter in front of a shared pipelined SCIE unit
// clock, reset      : rising-edge clock, synchronous active-low reset
// req0, req1        : requester channels (scie_arbiter_if.slave)
// scie_valid/insn/rs1/rs2 : issue port to the SCIE unit
// scie_rd           : SCIE result, valid LATENCY cycles after its issue
// perf_issue0/1, perf_conflict : counters, present only with SCIE_ARB_PERF_EN
module scie_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   scie_arbiter_if.slave req0,
   scie_arbiter_if.slave req1,
   output logic        scie_valid,
   output logic [31:0] scie_insn,
   output logic [31:0] scie_rs1,
   output logic [31:0] scie_rs2,
   input  logic [31:0] scie_rd
`ifdef SCIE_ARB_PERF_EN
   ,
   output logic [31:0] perf_issue0,
   output logic [31:0] perf_issue1,
   output logic [31:0] perf_conflict
`endif
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   state_t state, state_nxt;
   logic ptr, ready0, ready1, fire;
   logic [LATENCY-1:0] tag_v, tag_id;
   logic [LATENCY:0] tag_v_sh, tag_id_sh;
   logic exit_v, exit_id;
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = ready0 && state == IDLE && req0.lock ? LOCK0 :
                  ready1 && state == IDLE && req1.lock ? LOCK1 :
                  (ready0 && state == LOCK0 && !req0.lock) ||
                  (ready1 && state == LOCK1 && !req1.lock) ? IDLE : state;
   end
   // Ready already includes valid, so ready doubles as "transfer fires".
   // Everything is forced low while reset is held so outputs read 0.
   always_comb begin
      ready0 = reset && req0.valid && (state == LOCK0 || (state == IDLE && (!req1.valid || !ptr)));
      ready1 = reset && req1.valid && (state == LOCK1 || (state == IDLE && (!req0.valid || ptr)));
      fire   = ready0 || ready1;
      scie_valid = fire;
      scie_insn  = ready0 ? req0.insn : ready1 ? req1.insn : '0;
      scie_rs1   = ready0 ? req0.rs1  : ready1 ? req1.rs1  : '0;
      scie_rs2   = ready0 ? req0.rs2  : ready1 ? req1.rs2  : '0;
   end
   assign req0.ready = ready0;
   assign req1.ready = ready1;
   // Tag pipe: bit 0 enters on issue, bit LATENCY-1 exits alongside scie_rd.
   assign tag_v_sh  = {tag_v, fire};
   assign tag_id_sh = {tag_id, ready1};
   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr    <= 1'b0;
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         ptr    <= fire ? ready0 : ptr;
         tag_v  <= tag_v_sh[LATENCY-1:0];
         tag_id <= tag_id_sh[LATENCY-1:0];
      end
   end
   assign exit_v         = reset && tag_v[LATENCY-1];
   assign exit_id        = tag_id[LATENCY-1];
   assign req0.rsp_valid = exit_v && !exit_id;
   assign req1.rsp_valid = exit_v && exit_id;
   assign req0.rsp_rd    = req0.rsp_valid ? scie_rd : '0;
   assign req1.rsp_rd    = req1.rsp_valid ? scie_rd : '0;
`ifdef SCIE_ARB_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_issue0   <= '0;
         perf_issue1   <= '0;
         perf_conflict <= '0;
      end else begin
         perf_issue0   <= perf_issue0 + 32'(ready0);
         perf_issue1   <= perf_issue1 + 32'(ready1);
         perf_conflict <= perf_conflict + 32'((req0.valid && !ready0) || (req1.valid && !ready1));
      end
   end
`endif
endmodule

// File: tb/tb_scie_arbiter.sv
// tb_scie_arbiter: scoreboard bench driving LATENCY=1 and LATENCY=3 arbiters with identical requests
module tb_scie_arbiter;
   logic clk = 1'b0, reset = 1'b0;
   int cyc = 0, total = 0, bad = 0;
   logic [32:0] q1[$], q3[$];
   logic [31:0] rd;
   logic s1_v, s3_v;
   logic [31:0] s1_i, s1_r1, s1_r2, s3_i, s3_r1, s3_r2;
`ifdef SCIE_ARB_PERF_EN
   logic [31:0] p1_i0, p1_i1, p1_c, p3_i0, p3_i1, p3_c;
`endif
   scie_arbiter_if a0(), a1(), b0(), b1();
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign rd = {16'hC0DE, cyc[15:0]};
   assign b0.valid = a0.valid;
   assign b0.lock  = a0.lock;
   assign b0.insn  = a0.insn;
   assign b0.rs1   = a0.rs1;
   assign b0.rs2   = a0.rs2;
   assign b1.valid = a1.valid;
   assign b1.lock  = a1.lock;
   assign b1.insn  = a1.insn;
   assign b1.rs1   = a1.rs1;
   assign b1.rs2   = a1.rs2;
   scie_arbiter #(.LATENCY(1)) d1 (
      .clock(clk), .reset(reset), .req0(a0), .req1(a1),
      .scie_valid(s1_v), .scie_insn(s1_i), .scie_rs1(s1_r1), .scie_rs2(s1_r2), .scie_rd(rd)
`ifdef SCIE_ARB_PERF_EN
      , .perf_issue0(p1_i0), .perf_issue1(p1_i1), .perf_conflict(p1_c)
`endif
   );
   scie_arbiter #(.LATENCY(3)) d3 (
      .clock(clk), .reset(reset), .req0(b0), .req1(b1),
      .scie_valid(s3_v), .scie_insn(s3_i), .scie_rs1(s3_r1), .scie_rs2(s3_r2), .scie_rd(rd)
`ifdef SCIE_ARB_PERF_EN
      , .perf_issue0(p3_i0), .perf_issue1(p3_i1), .perf_conflict(p3_c)
`endif
   );
   function automatic logic [31:0] rdf(input int c);
      return {16'hC0DE, c[15:0]};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Monitors: pop the oldest expected response whenever a DUT presents one.
   always @(negedge clk) begin
      logic [32:0] e;
      if (a0.rsp_valid || a1.rsp_valid) begin
         if (q1.size() == 0) chk("L1 unexpected rsp", {30'd0, a1.rsp_valid, a0.rsp_valid}, 0);
         else begin
            e = q1.pop_front();
            chk("L1 rsp id", {30'd0, a1.rsp_valid, a0.rsp_valid}, e[32] ? 2 : 1);
            chk("L1 rsp rd", e[32] ? a1.rsp_rd : a0.rsp_rd, e[31:0]);
            chk("L1 rsp other rd", e[32] ? a0.rsp_rd : a1.rsp_rd, 0);
         end
      end else chk("L1 idle rd", a0.rsp_rd | a1.rsp_rd, 0);
   end
   always @(negedge clk) begin
      logic [32:0] e;
      if (b0.rsp_valid || b1.rsp_valid) begin
         if (q3.size() == 0) chk("L3 unexpected rsp", {30'd0, b1.rsp_valid, b0.rsp_valid}, 0);
         else begin
            e = q3.pop_front();
            chk("L3 rsp id", {30'd0, b1.rsp_valid, b0.rsp_valid}, e[32] ? 2 : 1);
            chk("L3 rsp rd", e[32] ? b1.rsp_rd : b0.rsp_rd, e[31:0]);
            chk("L3 rsp other rd", e[32] ? b0.rsp_rd : b1.rsp_rd, 0);
         end
      end else chk("L3 idle rd", b0.rsp_rd | b1.rsp_rd, 0);
   end
   // One cycle of stimulus; eg is the expected grant (0, 1, or 2 for none).
   task automatic step(input bit v0, input bit l0, input logic [31:0] n0,
                       input bit v1, input bit l1, input logic [31:0] n1, input int eg);
      logic [31:0] ei, e1, e2;
      a0.valid = v0; a0.lock = l0; a0.insn = n0;
      a0.rs1 = {16'h5100, n0[15:0]}; a0.rs2 = {16'h5200, n0[15:0]};
      a1.valid = v1; a1.lock = l1; a1.insn = n1;
      a1.rs1 = {16'h6100, n1[15:0]}; a1.rs2 = {16'h6200, n1[15:0]};
      ei = eg == 0 ? a0.insn : eg == 1 ? a1.insn : 0;
      e1 = eg == 0 ? a0.rs1 : eg == 1 ? a1.rs1 : 0;
      e2 = eg == 0 ? a0.rs2 : eg == 1 ? a1.rs2 : 0;
      @(negedge clk);
      chk("L1 ready0", 32'(a0.ready), 32'(eg == 0));
      chk("L1 ready1", 32'(a1.ready), 32'(eg == 1));
      chk("L3 ready0", 32'(b0.ready), 32'(eg == 0));
      chk("L3 ready1", 32'(b1.ready), 32'(eg == 1));
      chk("L1 scie_valid", 32'(s1_v), 32'(eg != 2));
      chk("L3 scie_valid", 32'(s3_v), 32'(eg != 2));
      chk("L1 scie_insn", s1_i, ei);
      chk("L1 scie_rs1", s1_r1, e1);
      chk("L1 scie_rs2", s1_r2, e2);
      chk("L3 scie_insn", s3_i, ei);
      if (eg != 2) begin
         q1.push_back({eg == 1, rdf(cyc + 1)});
         q3.push_back({eg == 1, rdf(cyc + 3)});
      end
      @(posedge clk); #1;
   endtask
   // One reset cycle with both requesters valid: everything must read 0,
   // and anything still in flight is forgotten.
   task automatic rst_cycle();
      reset = 1'b0;
      a0.valid = 1'b1; a1.valid = 1'b1;
      q1.delete(); q3.delete();
      @(negedge clk);
      chk("rst ready", {28'd0, a0.ready, a1.ready, b0.ready, b1.ready}, 0);
      chk("rst scie_valid", {30'd0, s1_v, s3_v}, 0);
      chk("rst scie_insn", s1_i | s3_i | s1_r1 | s1_r2, 0);
      chk("rst rsp_valid", {28'd0, a0.rsp_valid, a1.rsp_valid, b0.rsp_valid, b1.rsp_valid}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      a0.valid = 1'b0; a1.valid = 1'b0;
   endtask
   initial begin
      a0.valid = 0; a0.lock = 0; a0.insn = 0; a0.rs1 = 0; a0.rs2 = 0;
      a1.valid = 0; a1.lock = 0; a1.insn = 0; a1.rs1 = 0; a1.rs2 = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_cycle();
      for (int i = 0; i < 10; i++) step(1, 0, 32'h100 + i, 1, 0, 32'h200 + i, i % 2);
`ifdef SCIE_ARB_PERF_EN
      chk("perf_issue0", p1_i0, 5);
      chk("perf_issue1", p1_i1, 5);
      chk("perf_conflict", p1_c, 10);
      chk("L3 perf_conflict", p3_c, 10);
`endif
      step(1, 1, 32'h2B, 1, 0, 32'h300, 0);
      step(0, 0, 32'h0,  1, 0, 32'h301, 2);
      step(0, 0, 32'h0,  1, 0, 32'h302, 2);
      step(1, 0, 32'h5B, 1, 0, 32'h303, 0);
      step(1, 0, 32'h400, 1, 0, 32'h304, 1);
      step(0, 0, 32'h0,  1, 1, 32'h77, 1);
      step(1, 0, 32'h401, 1, 1, 32'h78, 1);
      step(1, 0, 32'h402, 0, 0, 32'h0,  2);
      step(1, 0, 32'h403, 1, 0, 32'h79, 1);
      step(1, 0, 32'h404, 1, 0, 32'h7A, 0);
      step(1, 0, 32'h405, 0, 0, 32'h0,  0);
      step(1, 0, 32'h0B, 0, 0, 32'h0,  0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 2);
      step(0, 0, 32'h0,  1, 1, 32'h99, 1);
      rst_cycle();
      step(1, 0, 32'h500, 1, 0, 32'h600, 0);
      step(1, 0, 32'h501, 1, 0, 32'h601, 1);
      repeat (5) step(0, 0, 0, 0, 0, 0, 2);
      chk("L1 leftover", q1.size(), 0);
      chk("L3 leftover", q3.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
